vga_timing_driver: RTL and testbench

Raster generator at the scan end of the Pong display path. It produces the pixel coordinates xpix/ypix consumed by DisplayController and registers the returned pixval/altcolor into RGB. It also generates hsync/vsync and a once-per-frame tick for game-logic update. Default timing is 640x480@60 with one pix_en tick per pixel.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_timing_driver.sv | 124 ++++++++++++
 tb/tb_vga_timing_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and colour codes
package vga_timing_pkg;

  // Counter width; both axis totals must fit in it (<= 1024)
  localparam int CNT_W = 10;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // RGB codes, packed as {red, green, blue}
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;
  localparam logic [2:0] COLOR_ALT   = 3'b100;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis counter with phase decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BP,
  parameter int W      = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         wrap_in,
  output logic [W-1:0] count,
  output logic         sync_phase,
  output logic         active_phase,
  output logic         wrap_out
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BACK;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  // Advance only when enabled and the faster axis (or a tie-high) says step
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && wrap_in) begin
      count <= wrap_out ? '0 : count + W'(1);
    end
  end

  // Phase decode and terminal count, all from the current count
  always_comb begin
    active_phase = (count < ACT_END);
    sync_phase   = (count >= SYNC_START) && (count < SYNC_END);
    wrap_out     = (count == LAST);
  end

endmodule

// File: rtl/vga_timing_driver.sv
// rtl/vga_timing_driver.sv - VGA raster timing and RGB output stage (optional TEST_PATTERN_EN)
module vga_timing_driver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
`ifdef TEST_PATTERN_EN
  input  logic             test_pattern,
`endif
  output logic [CNT_W-1:0] xpix,
  output logic [CNT_W-1:0] ypix,
  input  logic             pixval,
  input  logic             altcolor,
  output logic             hsync,
  output logic             vsync,
  output logic             red,
  output logic             green,
  output logic             blue,
  output logic             active,
  output logic             frame_tick
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_sync_ph;
  logic             h_act_ph;
  logic             h_wrap;
  logic             v_sync_ph;
  logic             v_act_ph;
  logic             v_wrap_unused;
  logic [2:0]       pix_rgb;
  logic             frame_start;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BACK   (H_BP),
    .W      (CNT_W)
  ) u_h_cnt (
    .clk          (clk),
    .reset        (reset),
    .en           (pix_en),
    .wrap_in      (1'b1),
    .count        (h_cnt),
    .sync_phase   (h_sync_ph),
    .active_phase (h_act_ph),
    .wrap_out     (h_wrap)
  );

  // Vertical axis steps only on the tick where the line wraps
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BACK   (V_BP),
    .W      (CNT_W)
  ) u_v_cnt (
    .clk          (clk),
    .reset        (reset),
    .en           (pix_en),
    .wrap_in      (h_wrap),
    .count        (v_cnt),
    .sync_phase   (v_sync_ph),
    .active_phase (v_act_ph),
    .wrap_out     (v_wrap_unused)
  );

  assign xpix = h_cnt;
  assign ypix = v_cnt;

  // Colour for the pixel at the current (pre-increment) counters
  always_comb begin
    pix_rgb = COLOR_BLACK;
    if (h_act_ph && v_act_ph) begin
`ifdef TEST_PATTERN_EN
      if (test_pattern) begin
        pix_rgb = {h_cnt[8], h_cnt[7], h_cnt[6]};
      end else if (pixval) begin
        pix_rgb = altcolor ? COLOR_ALT : COLOR_WHITE;
      end
`else
      if (pixval) begin
        pix_rgb = altcolor ? COLOR_ALT : COLOR_WHITE;
      end
`endif
    end
  end

  // Counters are about to step from the last visible line into blanking
  assign frame_start = pix_en && h_wrap && (v_cnt == CNT_W'(V_ACTIVE - 1));

  // Output stage: one pixel behind xpix/ypix, frame_tick a single clk wide
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      red        <= 1'b0;
      green      <= 1'b0;
      blue       <= 1'b0;
      active     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (pix_en) begin
        hsync              <= !h_sync_ph;
        vsync              <= !v_sync_ph;
        active             <= h_act_ph && v_act_ph;
        {red, green, blue} <= pix_rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_driver.sv
// tb/tb_vga_timing_driver.sv - self-checking bench for vga_timing_driver
module tb_vga_timing_driver;

  localparam int HA = 20;
  localparam int HF = 3;
  localparam int HS = 4;
  localparam int HB = 5;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 3;
  localparam int VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       pixval = 1'b0;
  logic       altcolor = 1'b0;
  logic [9:0] xpix;
  logic [9:0] ypix;
  logic       hsync;
  logic       vsync;
  logic       red;
  logic       green;
  logic       blue;
  logic       active;
  logic       frame_tick;
`ifdef TEST_PATTERN_EN
  logic       test_pattern = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_driver #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
`ifdef TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .xpix       (xpix),
    .ypix       (ypix),
    .pixval     (pixval),
    .altcolor   (altcolor),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .active     (active),
    .frame_tick (frame_tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: pixel-tick position within the frame plus expected registered outputs
  int         pos = 0;
  logic       e_hs, e_vs, e_act, e_ft;
  logic [2:0] e_rgb;

  int ft_cnt;
  int hs_run, vs_run;
  int rgb_hits;
  logic prev_hs, prev_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs, input logic pe, input logic pv, input logic ac);
    int h, v;
    reset = rs; pix_en = pe; pixval = pv; altcolor = ac;
    @(posedge clk);
    if (rs) begin
      pos = 0; e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_rgb = 3'b000; e_ft = 1'b0;
    end else begin
      e_ft = 1'b0;
      if (pe) begin
        h = pos % HT;
        v = pos / HT;
        e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e_act = (h < HA) && (v < VA);
        if (!e_act || !pv) e_rgb = 3'b000;
        else if (ac)       e_rgb = 3'b100;
        else               e_rgb = 3'b111;
        pos  = (pos + 1) % FT;
        e_ft = (pos == VA * HT);
      end
    end
    #1;
    chk("xpix", 32'(xpix), 32'(pos % HT));
    chk("ypix", 32'(ypix), 32'(pos / HT));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("active", 32'(active), 32'(e_act));
    chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    if (frame_tick === 1'b1) ft_cnt++;
  endtask

  // Sync pulse widths measured on the DUT outputs under continuous pix_en
  task automatic track_sync();
    if (hsync === 1'b0) hs_run++;
    else begin
      if (prev_hs === 1'b0) chk("hsync_width", 32'(hs_run), 32'(HS));
      hs_run = 0;
    end
    if (vsync === 1'b0) vs_run++;
    else begin
      if (prev_vs === 1'b0) chk("vsync_width", 32'(vs_run), 32'(VS * HT));
      vs_run = 0;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  initial begin
    // Reset held with pix_en running
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Free run two frames, random pixel data
    ft_cnt = 0; hs_run = 0; vs_run = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      track_sync();
    end
    chk("ft_count_free", 32'(ft_cnt), 32'd2);

    // pix_en 1-in-4 over two frames of pulses
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ft_cnt = 0;
    for (int i = 0; i < 8 * FT; i++) begin
      step(1'b0, (i % 4) == 0, 1'($urandom), 1'($urandom));
    end
    chk("ft_count_div4", 32'(ft_cnt), 32'd2);

    // Random pix_en density
    for (int i = 0; i < 1500; i++) begin
      step(1'b0, 1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom));
    end

    // Single lit pixel at (10,10), white then alternate colour
    for (int ac = 0; ac < 2; ac++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      rgb_hits = 0;
      for (int i = 0; i < FT; i++) begin
        step(1'b0, 1'b1, (pos % HT == 10) && (pos / HT == 10), 1'(ac));
        if ({red, green, blue} !== 3'b000) rgb_hits++;
      end
      chk("single_pixel_hits", 32'(rgb_hits), 32'd1);
    end

    // Constant pixval: colour only inside the visible area
    for (int i = 0; i < FT + 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'($urandom));
    end

    // Mid-frame reset at (15,8)
    for (int i = 0; i < 2 * FT && pos != 8 * HT + 15; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("reached_15_8", 32'(pos), 32'(8 * HT + 15));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
